// File: rtl/ldd_pkg.sv
// Shared types and default widths for the LDD burst controller.
// Optional watchdog build switch: LDD_MAX_ON_EN.
package ldd_pkg;

  localparam int WD_W_DEF  = 3;
  localparam int LEN_W_DEF = 32;
  localparam int REP_W_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_OFF  = 2'd2
  } ldd_state_e;

  typedef struct packed {
    logic [WD_W_DEF-1:0]  wdis;
    logic [LEN_W_DEF-1:0] on_len;
    logic [LEN_W_DEF-1:0] off_len;
    logic [REP_W_DEF-1:0] reps;
  } ldd_cmd_t;

endpackage

// File: rtl/ldd_cmd_slot.sv
// One-deep pending command register for back-to-back bursts.
// Flush and take both empty it; flush wins over a new push.
module ldd_cmd_slot #(
  parameter int W = 8
) (
  input  logic         clk200,
  input  logic         rst,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  input  logic         out_take
);

  assign in_ready = ~out_valid;

  // Capture a command when empty; drop it on take or flush.
  always_ff @(posedge clk200 or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (flush | out_take) begin
      out_valid <= 1'b0;
    end else if (in_valid & ~out_valid) begin
      out_valid <= 1'b1;
      out_data  <= in_data;
    end
  end

endmodule

// File: rtl/ldd_burst_ctrl.sv
// Pulse-burst gate driving the LDD wdis word, with chaining and abort.
// Define LDD_MAX_ON_EN to add the continuous-drive watchdog.
module ldd_burst_ctrl
  import ldd_pkg::*;
#(
  parameter int WD_W   = WD_W_DEF,
  parameter int LEN_W  = LEN_W_DEF,
  parameter int REP_W  = REP_W_DEF,
  parameter int MAX_ON = 200000000
) (
  input  logic             clk200,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WD_W-1:0]  cmd_wdis,
  input  logic [LEN_W-1:0] cmd_on_len,
  input  logic [LEN_W-1:0] cmd_off_len,
  input  logic [REP_W-1:0] cmd_reps,
  input  logic             cmd_close,
  output logic [WD_W-1:0]  wdis,
  output logic             busy,
  output logic             done,
  output logic             fault
);

  localparam int CMD_W = WD_W + 2 * LEN_W + REP_W;

  ldd_state_e       state, state_n;
  logic [WD_W-1:0]  wdis_n, wd_l, wd_l_n;
  logic [LEN_W-1:0] on_cnt, on_cnt_n;
  logic [LEN_W-1:0] off_cnt, off_cnt_n;
  logic [LEN_W-1:0] on_len_l, on_len_l_n;
  logic [LEN_W-1:0] off_len_l, off_len_l_n;
  logic [REP_W-1:0] rep_cnt, rep_cnt_n;
  logic             cont_l, cont_l_n;
  logic             busy_n, done_n;
  logic             acc, fin, load, push, take, trip;
  logic             slot_rdy, pend_valid;
  logic [CMD_W-1:0] pend_data;
  logic [WD_W-1:0]  p_wdis, s_wdis;
  logic [LEN_W-1:0] p_on, p_off, s_on, s_off;
  logic [REP_W-1:0] p_reps, s_reps;

  assign cmd_ready = ~cmd_close & ~fault
                   & ((state == ST_IDLE) | slot_rdy);
  assign acc = cmd_valid & cmd_ready;

  assign fin = (state == ST_ON) & ~cont_l
             & (on_cnt == LEN_W'(1))
             & (rep_cnt <= REP_W'(1));

  // A command offered in the completing cycle chains directly.
  assign load = (acc & (state == ST_IDLE))
              | (fin & (pend_valid | acc));
  assign push = acc & (state != ST_IDLE) & ~fin;
  assign take = fin & pend_valid;

  assign {p_wdis, p_on, p_off, p_reps} = pend_data;

  assign s_wdis = take ? p_wdis : cmd_wdis;
  assign s_on   = take ? p_on   : cmd_on_len;
  assign s_off  = take ? p_off  : cmd_off_len;
  assign s_reps = take ? p_reps : cmd_reps;

  ldd_cmd_slot #(.W(CMD_W)) u_slot (
    .clk200    (clk200),
    .rst       (rst),
    .flush     (cmd_close | trip),
    .in_valid  (push),
    .in_ready  (slot_rdy),
    .in_data   ({cmd_wdis, cmd_on_len, cmd_off_len, cmd_reps}),
    .out_valid (pend_valid),
    .out_data  (pend_data),
    .out_take  (take)
  );

  // Next-state: abort first, then command load, then burst sequencing.
  always_comb begin
    state_n     = state;
    wdis_n      = wdis;
    on_cnt_n    = on_cnt;
    off_cnt_n   = off_cnt;
    rep_cnt_n   = rep_cnt;
    wd_l_n      = wd_l;
    on_len_l_n  = on_len_l;
    off_len_l_n = off_len_l;
    cont_l_n    = cont_l;
    done_n      = 1'b0;
    if (cmd_close | trip) begin
      state_n   = ST_IDLE;
      wdis_n    = '0;
      on_cnt_n  = '0;
      off_cnt_n = '0;
      rep_cnt_n = '0;
    end else if (load) begin
      state_n     = ST_ON;
      wdis_n      = s_wdis;
      wd_l_n      = s_wdis;
      on_cnt_n    = s_on;
      on_len_l_n  = s_on;
      off_len_l_n = s_off;
      off_cnt_n   = '0;
      cont_l_n    = (s_on == '0);
      rep_cnt_n   = (s_reps == '0) ? REP_W'(1) : s_reps;
      done_n      = fin;
    end else begin
      unique case (state)
        ST_ON: begin
          if (!cont_l) begin
            if (on_cnt != LEN_W'(1)) begin
              on_cnt_n = on_cnt - LEN_W'(1);
            end else if (rep_cnt > REP_W'(1)) begin
              rep_cnt_n = rep_cnt - REP_W'(1);
              if (off_len_l != '0) begin
                state_n   = ST_OFF;
                wdis_n    = '0;
                on_cnt_n  = '0;
                off_cnt_n = off_len_l;
              end else begin
                on_cnt_n = on_len_l;
              end
            end else begin
              state_n   = ST_IDLE;
              wdis_n    = '0;
              on_cnt_n  = '0;
              rep_cnt_n = '0;
              done_n    = 1'b1;
            end
          end
        end
        ST_OFF: begin
          if (off_cnt == LEN_W'(1)) begin
            state_n   = ST_ON;
            wdis_n    = wd_l;
            on_cnt_n  = on_len_l;
            off_cnt_n = '0;
          end else begin
            off_cnt_n = off_cnt - LEN_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign busy_n = (state_n != ST_IDLE);

  // FSM state, counters and the latched burst parameters.
  always_ff @(posedge clk200 or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      on_cnt    <= '0;
      off_cnt   <= '0;
      rep_cnt   <= '0;
      wd_l      <= '0;
      on_len_l  <= '0;
      off_len_l <= '0;
      cont_l    <= 1'b0;
    end else begin
      state     <= state_n;
      on_cnt    <= on_cnt_n;
      off_cnt   <= off_cnt_n;
      rep_cnt   <= rep_cnt_n;
      wd_l      <= wd_l_n;
      on_len_l  <= on_len_l_n;
      off_len_l <= off_len_l_n;
      cont_l    <= cont_l_n;
    end
  end

  // Registered outputs toward the LDD path.
  always_ff @(posedge clk200 or posedge rst) begin
    if (rst) begin
      wdis <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      wdis <= wdis_n;
      busy <= busy_n;
      done <= done_n;
    end
  end

`ifdef LDD_MAX_ON_EN
  logic [LEN_W-1:0] wd_cnt;

  assign trip = (wdis != '0) & (wd_cnt == LEN_W'(MAX_ON - 1));

  // Count consecutive driven cycles; a trip latches until reset.
  always_ff @(posedge clk200 or posedge rst) begin
    if (rst) begin
      wd_cnt <= '0;
      fault  <= 1'b0;
    end else begin
      wd_cnt <= ((wdis == '0) | trip) ? '0 : wd_cnt + LEN_W'(1);
      if (trip) fault <= 1'b1;
    end
  end
`else
  logic unused_max_on;
  assign unused_max_on = (MAX_ON != 0);
  assign trip  = 1'b0;
  assign fault = 1'b0;
`endif

endmodule

// File: doc/ldd_burst_ctrl.md
Name: ldd_burst_ctrl

Overview:
- Successor to the single-shot laser-driver command gate.
- Drives the `wdis` word to the LDD path for programmable pulse bursts: ON length, OFF gap and repeat count per command.
- Adds a continuous mode, a 1-deep pending-command buffer for back-to-back bursts, and abort.
- Sits between the command decoder and the LDD DAC/enable logic in the `clk200` domain.

Parameters:
- WD_W, 3, width of the wdis word.
- LEN_W, 32, width of the ON/OFF length counters, in clk200 cycles.
- REP_W, 16, width of the repeat count.
- MAX_ON, 200000000, safety limit in cycles; used only with LDD_MAX_ON_EN.

Ports:
- clk200  in  1  sole clock, 200 MHz.
- rst  in  1  reset; asynchronous, active-high.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready.
- cmd_wdis  in  WD_W  drive word for the ON phase.
- cmd_on_len  in  LEN_W  ON cycles; 0 = continuous.
- cmd_off_len  in  LEN_W  OFF gap cycles between pulses.
- cmd_reps  in  REP_W  pulses per burst; 0 is treated as 1.
- cmd_close  in  1  abort: level, sampled each cycle.
- wdis  out  WD_W  LDD drive word; 0 = off.
- busy  out  1  high in ON or OFF state.
- done  out  1  1-cycle pulse on natural burst completion.
- fault  out  1  sticky watchdog trip; tied 0 without LDD_MAX_ON_EN.

Behaviour:
- Reset (async): state=IDLE; wdis=0, busy=0, done=0, fault=0; pending buffer empty; all counters 0.
- States: IDLE, ON, OFF. All outputs are registered.
- cmd_ready = !cmd_close & !fault & (state==IDLE | !pend_valid).
- IDLE + accepted command:
  - next cycle state=ON, wdis=cmd_wdis; on_cnt=cmd_on_len, rep_cnt=max(cmd_reps,1).
  - off_len and the continuous flag are latched with the command.
- ON, on_len=0 (continuous): hold wdis until cmd_close. rep/off are ignored.
- ON, on_len=N: wdis is nonzero for exactly N cycles. on_cnt decrements each cycle; the transition is taken when on_cnt==1. Then:
  - rep_cnt>1 and off_len>0: go to OFF, wdis=0, off_cnt=off_len, rep_cnt-1.
  - rep_cnt>1 and off_len=0: reload on_cnt, rep_cnt-1, stay ON; wdis is continuous across pulses.
  - rep_cnt==1: burst ends. No trailing OFF gap. done=1 for one cycle.
    - Pending empty: go to IDLE, wdis=0.
    - Pending valid: load it, stay ON with the new wdis in that same cycle (zero-gap chaining), clear pend_valid.
- OFF: wdis=0. When off_cnt==1, go to ON, reload on_cnt, wdis=latched word.
- Pending buffer: a command accepted while busy is stored, 1 deep. cmd_ready is low while it is full.
- cmd_close high in any state:
  - next cycle state=IDLE, wdis=0, pend_valid=0, done stays 0.
  - cmd_ready is low that cycle, so no command is accepted concurrently.
  - Close takes priority over natural completion in the same cycle.
- Counters never wrap. Lengths equal to 2^LEN_W-1 are legal.
- Reset mid-burst: wdis=0 immediately (asynchronous), buffer is lost.

Optional Feature:
- Macro LDD_MAX_ON_EN.
- Defined:
  - A watchdog counts consecutive cycles with wdis!=0 and clears on any wdis==0 cycle.
  - When the count reaches MAX_ON: next cycle wdis=0, state=IDLE, buffer flushed, fault=1.
  - fault stays set until rst. cmd_ready stays low while fault is set.
- Undefined: no watchdog logic; fault is constant 0; continuous mode is unbounded.

Decomposition:
- Package ldd_pkg:
  - state enum type (IDLE/ON/OFF);
  - command struct type (wdis, on_len, off_len, reps);
  - WD_W/LEN_W/REP_W default constants.
- Sub-module ldd_cmd_slot: the 1-deep pending register with valid/ready handshake and flush input.
- The FSM and counters stay in the top module.

Test Plan:
- Single pulse: wdis=5, on=4, reps=1, from IDLE -> wdis=5 for exactly 4 cycles starting the cycle after acceptance; done pulses in the cycle wdis returns to 0; busy is low in that cycle.
- Burst: wdis=3, on=2, off=3, reps=3 -> pattern 3,3,0,0,0,3,3,0,0,0,3,3 then 0; one done; no trailing gap.
- Chaining: during the burst above, offer wdis=6, on=1 -> accepted, cmd_ready then low; wdis=6 appears in the cycle right after the last 3; a second offer stalls until the slot empties.
- Continuous + close: on=0, wdis=7 -> wdis=7 held for 1000 cycles; close asserted -> wdis=0 next cycle, no done, pending flushed.
- Edge cases:
  - reps=0 behaves as reps=1.
  - off=0, reps=3, on=2 gives 6 continuous cycles.
  - close in the same cycle as the last ON cycle gives no done.
  - async rst mid-OFF clears all outputs without a clock edge.
- LDD_MAX_ON_EN with MAX_ON=50, continuous command -> wdis drops after 50 ON cycles; fault=1; new commands refused until rst.
